// File: rtl/mips_pkg.sv
// Shared fetch-stage types and constants.
package mips_pkg;

    // Fetch controller states.
    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StWait     = 2'd1,
        StHold     = 2'd2,
        StRedirect = 2'd3
    } fetch_state_t;

    localparam logic [31:0] PC_INCR = 32'd4;

    // Instruction addresses are word aligned; low two bits are forced to zero.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry hold buffer for a fetched word that arrived while IF/ID was stalled.
module fetch_skid (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc,
    output logic [31:0] instr,
    output logic [31:0] pc
);

    logic [31:0] instr_q;
    logic [31:0] pc_q;

    // Capture a word on load; reset or clear empties the entry.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            instr_q <= '0;
            pc_q    <= '0;
        end else if (load) begin
            instr_q <= load_instr;
            pc_q    <= load_pc;
        end
    end

    assign instr = instr_q;
    assign pc    = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, memory handshake, stall hold and
// branch redirection with flush of the two younger pipeline stages.
module fetch_ctrl
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        flush
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  target_q, target_d;
    logic [31:0]  last_instr_q;
    logic [31:0]  last_pc_q;

    logic         skid_load;
    logic         skid_clear;
    logic         from_skid;
    logic [31:0]  skid_instr;
    logic [31:0]  skid_pc;
    logic [31:0]  dlv_instr;
    logic [31:0]  dlv_pc;
    logic [31:0]  branch_pc;

    assign branch_pc = word_align(branch_target);
    assign imem_addr = pc_q;

    fetch_skid u_skid (
        .clk        (clk),
        .reset      (reset),
        .load       (skid_load),
        .clear      (skid_clear),
        .load_instr (imem_rdata),
        .load_pc    (pc_q),
        .instr      (skid_instr),
        .pc         (skid_pc)
    );

    // Next-state, PC update and handshake outputs; branch outranks every other event.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        target_d   = target_q;
        imem_req   = 1'b0;
        if_valid   = 1'b0;
        flush      = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        from_skid  = 1'b0;
        if (!reset) begin
            unique case (state_q)
                StRun: begin
                    imem_req = !stall && !branch;
                    if (branch) begin
                        flush = 1'b1;
                        pc_d  = branch_pc;
                    end else if (imem_req) begin
                        if (imem_ready) begin
                            if_valid = 1'b1;
                            pc_d     = pc_q + PC_INCR;
                        end else begin
                            state_d = StWait;
                        end
                    end
                end
                StWait: begin
                    // An issued request stays up at the same address until it completes.
                    imem_req = 1'b1;
                    if (branch) begin
                        flush = 1'b1;
                        if (imem_ready) begin
                            pc_d    = branch_pc;
                            state_d = StRun;
                        end else begin
                            target_d = branch_pc;
                            state_d  = StRedirect;
                        end
                    end else if (imem_ready) begin
                        pc_d = pc_q + PC_INCR;
                        if (stall) begin
                            skid_load = 1'b1;
                            state_d   = StHold;
                        end else begin
                            if_valid = 1'b1;
                            state_d  = StRun;
                        end
                    end
                end
                StHold: begin
                    if (branch) begin
                        flush      = 1'b1;
                        pc_d       = branch_pc;
                        skid_clear = 1'b1;
                        state_d    = StRun;
                    end else if (!stall) begin
                        if_valid   = 1'b1;
                        from_skid  = 1'b1;
                        skid_clear = 1'b1;
                        state_d    = StRun;
                    end
                end
                StRedirect: begin
                    // Drain the stale access at the old PC; its data is thrown away.
                    imem_req = 1'b1;
                    if (branch) begin
                        flush    = 1'b1;
                        target_d = branch_pc;
                        if (imem_ready) begin
                            pc_d    = branch_pc;
                            state_d = StRun;
                        end
                    end else if (imem_ready) begin
                        pc_d    = target_q;
                        state_d = StRun;
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    assign dlv_instr = from_skid ? skid_instr : imem_rdata;
    assign dlv_pc    = from_skid ? skid_pc : pc_q;
    assign if_instr  = if_valid ? dlv_instr : last_instr_q;
    assign if_pc     = if_valid ? dlv_pc : last_pc_q;

    // State, PC, saved target and last-delivered word registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StRun;
            pc_q         <= word_align(RESET_PC);
            target_q     <= '0;
            last_instr_q <= '0;
            last_pc_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            target_q <= target_d;
            if (if_valid) begin
                last_instr_q <= dlv_instr;
                last_pc_q    <= dlv_pc;
            end
        end
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] SHALL be zero.
REQ-002 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 stall  input  1  hazard hold; IF/ID SHALL NOT load while high.
REQ-005 branch  input  1  taken branch resolved in stage 3.
REQ-006 branch_target  input  32  absolute branch target; bits [1:0] SHALL be ignored and treated as 00.
REQ-007 imem_req  output  1  instruction-memory request.
REQ-008 imem_addr  output  32  request address, always equal to the current PC.
REQ-009 imem_ready  input  1  same-cycle completion; imem_rdata valid when high.
REQ-010 imem_rdata  input  32  fetched instruction word.
REQ-011 if_valid  output  1  IF/ID SHALL load if_instr/if_pc this cycle.
REQ-012 if_instr  output  32  instruction delivered to IF/ID.
REQ-013 if_pc  output  32  address of if_instr.
REQ-014 flush  output  1  kill the two younger in-flight instructions (IF/ID, ID/EX).

Function
REQ-015 States SHALL be RUN, WAIT, HOLD, REDIRECT; the PC SHALL advance by 4 modulo 2^32 (0xFFFF_FFFC wraps to 0).
REQ-016 A request, once asserted, SHALL remain asserted with an unchanged imem_addr until imem_ready, regardless of stall or branch.
REQ-017 RUN: imem_req = !stall & !branch; on req & ready: if_valid=1, if_instr=imem_rdata, if_pc=PC, PC+=4, stay RUN; on req & !ready: go to WAIT.
REQ-018 WAIT: imem_req=1; on ready & !stall: deliver as REQ-017, PC+=4, go to RUN; on ready & stall: latch rdata and PC into the hold buffer, PC+=4, go to HOLD.
REQ-019 HOLD: imem_req=0; on !stall: if_valid=1 from the hold buffer, go to RUN.
REQ-020 REDIRECT: imem_req=1 at the old PC; on ready: discard rdata (if_valid=0), PC <= saved target, go to RUN.
REQ-021 branch SHALL have priority over all other events: flush=1 in the same cycle (combinational) and if_valid=0 that cycle.
REQ-022 branch in RUN or HOLD, or in WAIT with imem_ready=1: PC <= branch_target, hold buffer discarded, go to RUN.
REQ-023 branch in WAIT with imem_ready=0: save branch_target, go to REDIRECT.
REQ-024 branch in REDIRECT: overwrite the saved target; if imem_ready=1 that cycle, PC <= the new branch_target, go to RUN.
REQ-025 if_valid SHALL never be high while stall is high.
REQ-026 Fetch-to-IF/ID latency SHALL be 0 cycles beyond imem_ready; branch-to-target-request latency SHALL be 1 cycle when no access is outstanding.

Reset
REQ-027 While reset is high: imem_req=0, if_valid=0, flush=0 (forced), and on the clock edge state <= RUN, PC <= RESET_PC, hold buffer and saved target cleared to 0.
REQ-028 Reset in WAIT/REDIRECT SHALL abandon the outstanding request; the memory responder is reset by the same reset.
REQ-029 if_instr and if_pc SHALL read 0 after reset until the first delivery.

Structure
REQ-030 State encoding (fetch_state_t) and the constant PC_INCR=4 SHALL reside in the shared mips_pkg package.
REQ-031 The one-entry hold buffer (instr+pc, load/clear) SHALL be a sub-module named fetch_skid; everything else stays in fetch_ctrl.

Verification
REQ-032 Reset, then imem_ready=1 constant, no stall: if_pc = 0,4,8,12 on consecutive cycles with if_valid=1 each cycle.
REQ-033 imem_ready low for 3 cycles at PC=0x10: imem_req held, imem_addr=0x10 for 4 cycles; single delivery of if_pc=0x10, then 0x14.
REQ-034 WAIT at 0x20, ready arrives with stall=1 for 2 cycles: state HOLD, imem_req=0; after stall drops, if_pc=0x20 delivered once, next request at 0x24.
REQ-035 branch=1, branch_target=0x103 in RUN at PC=0x40: flush=1 that cycle, if_valid=0; next cycle imem_addr=0x100.
REQ-036 branch target 0x200 in WAIT (PC=0x50, not ready) then ready after 2 cycles: 0x50 data discarded, if_valid=0, next imem_addr=0x200; a second branch to 0x300 during REDIRECT yields 0x300.
REQ-037 Reset asserted in WAIT at PC=0x60: imem_req=0 during reset; after release imem_addr=RESET_PC; PC=0xFFFF_FFFC fetch yields next imem_addr=0.
